// File: rtl/pcpi_arbiter_if.sv
// pcpi_arbiter_if: bundle of the requester-side and coprocessor-side PCPI
// signals handled by pcpi_arbiter.
//   req_valid/req_insn/req_rs1/req_rs2 : requests, requester i in word i
//   req_ready/req_wr/req_rd/req_busy   : responses back to the requesters
//   cp_valid/cp_insn/cp_rs1/cp_rs2     : request to the shared coprocessor
//   cp_ready/cp_wr/cp_rd               : coprocessor completion
//   grant_id/timeout_err               : arbitration status
// Modports: slave = arbiter view, master = environment view.
interface pcpi_arbiter_if #(
  parameter int unsigned NREQ = 2
);
  logic [NREQ-1:0]      req_valid;
  logic [32*NREQ-1:0]   req_insn;
  logic [32*NREQ-1:0]   req_rs1;
  logic [32*NREQ-1:0]   req_rs2;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      req_wr;
  logic [31:0]          req_rd;
  logic [NREQ-1:0]      req_busy;

  logic                 cp_valid;
  logic [31:0]          cp_insn;
  logic [31:0]          cp_rs1;
  logic [31:0]          cp_rs2;
  logic                 cp_ready;
  logic                 cp_wr;
  logic [31:0]          cp_rd;

  logic [1:0]           grant_id;
  logic                 timeout_err;

  modport slave (
    input  req_valid, req_insn, req_rs1, req_rs2,
    input  cp_ready, cp_wr, cp_rd,
    output req_ready, req_wr, req_rd, req_busy,
    output cp_valid, cp_insn, cp_rs1, cp_rs2,
    output grant_id, timeout_err
  );

  modport master (
    output req_valid, req_insn, req_rs1, req_rs2,
    output cp_ready, cp_wr, cp_rd,
    input  req_ready, req_wr, req_rd, req_busy,
    input  cp_valid, cp_insn, cp_rs1, cp_rs2,
    input  grant_id, timeout_err
  );
endinterface

// File: rtl/pcpi_arbiter.sv
// pcpi_arbiter: round-robin arbiter sharing one PCPI coprocessor between
// NREQ (2..4) requesters. Only M-extension and CUSTOM_OPCODE instructions
// are eligible. A grant is held for the whole operation, the result is
// registered back to the winner one cycle after cp_ready, and a watchdog
// forces a release (rd=0, wr=0, timeout_err pulse) after TIMEOUT cycles.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : pcpi_arbiter_if.slave (requester and coprocessor signals)
module pcpi_arbiter #(
  parameter int unsigned NREQ          = 2,
  parameter logic [6:0]  CUSTOM_OPCODE = 7'b0001011,
  parameter int unsigned TIMEOUT       = 64
) (
  input  logic           clk,
  input  logic           reset,
  pcpi_arbiter_if.slave  bus
);

  localparam int unsigned     CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic [1:0]      grant_q;
  logic [CW-1:0]   cnt_q;
  logic [31:0]     insn_q;
  logic [31:0]     rs1_q;
  logic [31:0]     rs2_q;
  logic [31:0]     rd_q;
  logic            wr_q;
  logic            err_q;
  logic            served_q;

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] cand;
  logic [NREQ-1:0] grant_oh;
  logic [NREQ-1:0] pick_oh;
  logic [1:0]      pick_idx;
  logic            pick_found;
  logic [31:0]     sel_insn;
  logic [31:0]     sel_rs1;
  logic [31:0]     sel_rs2;

  logic            grant_en;
  logic            cap_ready;
  logic            cap_timeout;

  // Eligibility: MUL/DIV (OP opcode with funct7=0000001) or the custom opcode.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      elig[i] = bus.req_valid[i] &&
                (((bus.req_insn[32*i +: 7] == 7'b0110011) &&
                  (bus.req_insn[32*i+25 +: 7] == 7'b0000001)) ||
                 (bus.req_insn[32*i +: 7] == CUSTOM_OPCODE));
    end
  end

  always_comb begin
    grant_oh = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      grant_oh[i] = ({30'd0, grant_q} == i);
    end
  end

  // The requester answered in the previous RESP still shows req_valid for
  // one more cycle; hide it so the stale request is not granted again.
  assign cand = elig & ~(served_q ? grant_oh : '0);

  // Round-robin search starting at grant_q+1, written with constant
  // indices only so the selection stays a flat mux.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = grant_q;
    pick_oh    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!pick_found && cand[i] &&
            (i == (({30'd0, grant_q} + k) % NREQ))) begin
          pick_found = 1'b1;
          pick_idx   = 2'(i);
          pick_oh[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_insn = '0;
    sel_rs1  = '0;
    sel_rs2  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) begin
        sel_insn = bus.req_insn[32*i +: 32];
        sel_rs1  = bus.req_rs1[32*i +: 32];
        sel_rs2  = bus.req_rs2[32*i +: 32];
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_d         = state_q;
    grant_en        = 1'b0;
    cap_ready       = 1'b0;
    cap_timeout     = 1'b0;
    bus.cp_valid    = 1'b0;
    bus.req_busy    = '0;
    bus.req_ready   = '0;
    bus.req_wr      = '0;
    bus.req_rd      = '0;
    bus.timeout_err = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_en = 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        bus.cp_valid = 1'b1;
        bus.req_busy = grant_oh;
        // cp_ready takes priority over a watchdog expiry in the same cycle.
        if (bus.cp_ready) begin
          cap_ready = 1'b1;
          state_d   = RESP;
        end else if (cnt_q == CNT_LAST) begin
          cap_timeout = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        bus.req_ready   = grant_oh;
        bus.req_wr      = wr_q ? grant_oh : '0;
        bus.req_rd      = rd_q;
        bus.timeout_err = err_q;
        state_d         = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Grant, operand latch, watchdog and result capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q  <= 2'(NREQ - 1);
      cnt_q    <= '0;
      insn_q   <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      served_q <= 1'b0;
    end else begin
      served_q <= (state_q == RESP);

      if (grant_en) begin
        grant_q <= pick_idx;
        insn_q  <= sel_insn;
        rs1_q   <= sel_rs1;
        rs2_q   <= sel_rs2;
        cnt_q   <= '0;
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q + CW'(1);
      end

      if (cap_ready) begin
        rd_q <= bus.cp_rd;
        wr_q <= bus.cp_wr;
      end else if (cap_timeout) begin
        rd_q  <= '0;
        wr_q  <= 1'b0;
        err_q <= 1'b1;
      end

      if (state_q == RESP) begin
        err_q <= 1'b0;
      end
    end
  end

  assign bus.grant_id = grant_q;
  assign bus.cp_insn  = insn_q;
  assign bus.cp_rs1   = rs1_q;
  assign bus.cp_rs2   = rs2_q;

endmodule

// File: tb/tb_pcpi_arbiter.sv
// tb_pcpi_arbiter: self-checking bench for pcpi_arbiter (NREQ=3, TIMEOUT=64).
// A coprocessor model answers after a programmable latency; expected
// responses are queued when requests are issued and compared when
// req_ready fires.
module tb_pcpi_arbiter;

  localparam int         NREQ          = 3;
  localparam int         TIMEOUT       = 64;
  localparam logic [6:0] CUSTOM_OPCODE = 7'b0001011;
  localparam int         W             = 32 * NREQ;

  localparam logic [31:0] I_MUL  = 32'h02B50533;
  localparam logic [31:0] I_DIVU = 32'h02B55533;
  localparam logic [31:0] I_CUST = 32'h00B5050B;
  localparam logic [31:0] I_ADD  = 32'h00B50533;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pcpi_arbiter_if #(.NREQ(NREQ)) bus ();

  pcpi_arbiter #(
    .NREQ(NREQ),
    .CUSTOM_OPCODE(CUSTOM_OPCODE),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    int          idx;
    logic [31:0] rd;
    logic        wr;
    logic        err;
    int          cyc;
  } exp_t;

  typedef struct {
    int          idx;
    logic [31:0] insn;
    logic [31:0] rs1;
    logic [31:0] rs2;
    int          lat;
    logic        cpwr;
    logic [31:0] rd;
    logic        wr;
    logic        err;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[9];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int hold[NREQ];
  int cp_cnt = 0;
  int cp_lat = 0;
  logic cp_wr_val = 1'b1;
  logic cp_force = 1'b0;

  function automatic logic [NREQ-1:0] oh(input int idx);
    return NREQ'(1) << idx;
  endfunction

  function automatic logic [W-1:0] put_word(input logic [W-1:0] v, input int idx,
                                            input logic [31:0] w);
    logic [W-1:0] m;
    m = {{(W-32){1'b0}}, 32'hFFFF_FFFF} << (32 * idx);
    return (v & ~m) | (W'(w) << (32 * idx));
  endfunction

  function automatic logic [31:0] cp_calc(input logic [31:0] insn,
                                          input logic [31:0] a, input logic [31:0] b);
    if (insn[6:0] == 7'b0110011) begin
      case (insn[14:12])
        3'd0:    return a * b;
        3'd5:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
        default: return a ^ b;
      endcase
    end
    return a ^ b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    chk("ready_onehot", 32'($countones(bus.req_ready) <= 1), 32'd1);
    if (bus.req_ready != '0) begin
      if (sb.size() == 0) begin
        chk("unexpected_ready", 32'(bus.req_ready), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_ready", 32'(bus.req_ready), 32'(oh(e.idx)));
        chk("resp_wr", 32'(bus.req_wr), e.wr ? 32'(oh(e.idx)) : 32'd0);
        chk("resp_rd", bus.req_rd, e.rd);
        chk("resp_timeout_err", 32'(bus.timeout_err), 32'(e.err));
        chk("resp_cp_valid_low", 32'(bus.cp_valid), 32'd0);
        if (e.cyc >= 0) chk("resp_cycle", cyc, e.cyc);
      end
    end else begin
      chk("quiet_outputs", {bus.req_rd[31:8],
                            bus.req_rd[7:0] | 8'(bus.req_wr) | {7'd0, bus.timeout_err}},
          32'd0);
    end
  endtask

  // One clock: sample at the falling edge, then update requesters and
  // the coprocessor model.
  task automatic tick();
    @(negedge clk);
    cyc++;
    monitor();
    for (int i = 0; i < NREQ; i++) begin
      if ((bus.req_ready & oh(i)) != '0) begin
        if (hold[i] > 0) hold[i]--;
        else bus.req_valid = bus.req_valid & ~oh(i);
      end
    end
    if (cp_force) begin
      cp_cnt       = 0;
      bus.cp_ready = 1'b1;
      bus.cp_wr    = 1'b1;
      bus.cp_rd    = 32'hDEAD_BEEF;
    end else if (bus.cp_valid) begin
      cp_cnt++;
      if (cp_lat != 0 && cp_cnt == cp_lat) begin
        bus.cp_ready = 1'b1;
        bus.cp_wr    = cp_wr_val;
        bus.cp_rd    = cp_calc(bus.cp_insn, bus.cp_rs1, bus.cp_rs2);
      end else begin
        bus.cp_ready = 1'b0;
        bus.cp_wr    = 1'b0;
        bus.cp_rd    = '0;
      end
    end else begin
      cp_cnt       = 0;
      bus.cp_ready = 1'b0;
      bus.cp_wr    = 1'b0;
      bus.cp_rd    = '0;
    end
  endtask

  task automatic issue(input int idx, input logic [31:0] insn,
                       input logic [31:0] a, input logic [31:0] b);
    bus.req_insn  = put_word(bus.req_insn, idx, insn);
    bus.req_rs1   = put_word(bus.req_rs1, idx, a);
    bus.req_rs2   = put_word(bus.req_rs2, idx, b);
    bus.req_valid = bus.req_valid | oh(idx);
  endtask

  task automatic push(input int idx, input logic [31:0] rd, input logic wr,
                      input logic err, input int at);
    exp_t e;
    e.idx = idx; e.rd = rd; e.wr = wr; e.err = err; e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic run_until_empty(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding after %0d cycles",
               sb.size(), budget);
      sb.delete();
      bus.req_valid = '0;
      repeat (TIMEOUT + 4) tick();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cp_valid"}, 32'(bus.cp_valid), 32'd0);
    chk({tag, "_cp_insn"}, bus.cp_insn, 32'd0);
    chk({tag, "_cp_rs1"}, bus.cp_rs1, 32'd0);
    chk({tag, "_cp_rs2"}, bus.cp_rs2, 32'd0);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    chk({tag, "_req_wr"}, 32'(bus.req_wr), 32'd0);
    chk({tag, "_req_rd"}, bus.req_rd, 32'd0);
    chk({tag, "_req_busy"}, 32'(bus.req_busy), 32'd0);
    chk({tag, "_timeout_err"}, 32'(bus.timeout_err), 32'd0);
    chk({tag, "_grant_id"}, 32'(bus.grant_id), 32'(NREQ - 1));
  endtask

  initial begin
    int base;
    int eff;
    int busy_cycles;

    //         idx insn    rs1           rs2      lat cpwr rd            wr    err
    vecs[0] = '{0, I_MUL,  32'd7,        32'd6,   5,  1'b1, 32'd42,       1'b1, 1'b0};
    vecs[1] = '{1, I_DIVU, 32'd100,      32'd7,   36, 1'b1, 32'd14,       1'b1, 1'b0};
    vecs[2] = '{2, I_CUST, 32'h0000F0F0, 32'h0FF0, 3, 1'b1, 32'h0000FF00, 1'b1, 1'b0};
    vecs[3] = '{0, I_MUL,  32'hFFFFFFFF, 32'd2,   1,  1'b1, 32'hFFFFFFFE, 1'b1, 1'b0};
    vecs[4] = '{1, I_MUL,  32'd3,        32'd5,   1,  1'b0, 32'd15,       1'b0, 1'b0};
    vecs[5] = '{0, I_MUL,  32'd7,        32'd6,   0,  1'b1, 32'd0,        1'b0, 1'b1};
    vecs[6] = '{1, I_MUL,  32'd3,        32'd5,   64, 1'b1, 32'd15,       1'b1, 1'b0};
    vecs[7] = '{2, I_MUL,  32'd9,        32'd9,   65, 1'b1, 32'd0,        1'b0, 1'b1};
    vecs[8] = '{2, I_MUL,  32'd9,        32'd9,   63, 1'b1, 32'd81,       1'b1, 1'b0};

    for (int i = 0; i < NREQ; i++) hold[i] = 0;
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_insn  = '0;
    bus.req_rs1   = '0;
    bus.req_rs2   = '0;
    bus.cp_ready  = 1'b0;
    bus.cp_wr     = 1'b0;
    bus.cp_rd     = '0;

    repeat (3) tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();

    // Fairness: req0 and req1 each hold DIVU for two grants.
    cp_lat = 10; cp_wr_val = 1'b1;
    base = cyc;
    hold[0] = 1; hold[1] = 1;
    issue(0, I_DIVU, 32'd100, 32'd7);
    issue(1, I_DIVU, 32'd100, 32'd7);
    for (int n = 0; n < 4; n++) push(n % 2, 32'd14, 1'b1, 1'b0, base + 11 + n * 12);
    run_until_empty(200);
    chk("fair_last_grant", 32'(bus.grant_id), 32'd1);
    repeat (3) tick();

    // Table-driven single operations.
    foreach (vecs[v]) begin
      cp_lat    = vecs[v].lat;
      cp_wr_val = vecs[v].cpwr;
      eff       = (vecs[v].lat == 0 || vecs[v].lat > TIMEOUT) ? TIMEOUT : vecs[v].lat;
      base      = cyc;
      issue(vecs[v].idx, vecs[v].insn, vecs[v].rs1, vecs[v].rs2);
      push(vecs[v].idx, vecs[v].rd, vecs[v].wr, vecs[v].err, base + eff + 1);
      tick();
      chk("vec_cp_valid", 32'(bus.cp_valid), 32'd1);
      chk("vec_req_busy", 32'(bus.req_busy), 32'(oh(vecs[v].idx)));
      chk("vec_cp_insn", bus.cp_insn, vecs[v].insn);
      chk("vec_cp_rs2", bus.cp_rs2, vecs[v].rs2);
      bus.req_rs1 = put_word(bus.req_rs1, vecs[v].idx, ~vecs[v].rs1);
      bus.req_rs2 = put_word(bus.req_rs2, vecs[v].idx, ~vecs[v].rs2);
      tick();
      chk("vec_cp_rs1_held", bus.cp_rs1, vecs[v].rs1);
      run_until_empty(TIMEOUT + 20);
      chk("vec_grant_id", 32'(bus.grant_id), 32'(vecs[v].idx));
      repeat (3) tick();
    end

    // Ineligible ADD on req1 must never be granted.
    busy_cycles = 0;
    issue(1, I_ADD, 32'd1, 32'd2);
    repeat (100) begin
      tick();
      if (bus.cp_valid || bus.req_busy != '0) busy_cycles++;
    end
    chk("inelig_busy_cycles", busy_cycles, 32'd0);
    cp_lat = 5; cp_wr_val = 1'b1;
    base = cyc;
    issue(0, I_MUL, 32'd7, 32'd6);
    push(0, 32'd42, 1'b1, 1'b0, base + 6);
    run_until_empty(50);
    bus.req_valid = '0;
    repeat (3) tick();

    // Reset in the middle of a DIV with req1 waiting.
    cp_lat = 36; cp_wr_val = 1'b1;
    issue(0, I_DIVU, 32'd100, 32'd7);
    tick();
    tick();
    issue(1, I_MUL, 32'd3, 32'd5);
    repeat (8) tick();
    chk("middiv_busy", 32'(bus.req_busy), 32'(oh(0)));
    reset = 1'b1;
    #1;
    chk_all_zero("middiv");
    cp_force = 1'b1;
    repeat (2) tick();
    reset    = 1'b0;
    cp_force = 1'b0;
    base     = cyc;
    push(0, 32'd14, 1'b1, 1'b0, base + 37);
    push(1, 32'd15, 1'b1, 1'b0, base + 37 + 38);
    run_until_empty(200);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
